// File: rtl/avalon_bridge_pkg.sv
// Shared types and constants for the Avalon-MM stall-injecting bridge.
package avalon_bridge_pkg;

    typedef enum logic [1:0] {IDLE, STALL, ISSUE, DONE} bridge_state_t;

    typedef enum logic {OP_RD, OP_WR} op_t;

    // Galois feedback mask for x^16 + x^14 + x^13 + x^11 (right-shifting form)
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/stall_lfsr.sv
// 16-bit Galois LFSR that steps once per cycle while i_adv is high.
module stall_lfsr
    import avalon_bridge_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_adv,
    output logic [15:0] o_lfsr
);

    logic [15:0] r_lfsr;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_lfsr <= SEED;
        end else if (i_adv) begin
            r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? LFSR_TAPS : 16'h0000);
        end
    end

    assign o_lfsr = r_lfsr;

endmodule

// File: rtl/avalon_stall_bridge.sv
// Avalon-MM CPU-to-RAM bridge that injects wait states, counts transfers and flags protocol errors.
// Build option: define AVB_STALL_LFSR_EN for pseudo-random stall lengths instead of WAIT_CYCLES.
module avalon_stall_bridge
    import avalon_bridge_pkg::*;
#(
    parameter int          ADDR_W      = 32,
    parameter int          DATA_W      = 32,
    parameter int          WAIT_CYCLES = 2,
    parameter int          MAX_WAIT    = 7,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1,
    parameter int          CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_W-1:0]     address,
    input  logic                  read,
    input  logic                  write,
    input  logic [DATA_W-1:0]     writedata,
    input  logic [DATA_W/8-1:0]   byteenable,
    output logic                  waitrequest,
    output logic [DATA_W-1:0]     readdata,
    output logic [ADDR_W-1:0]     s_address,
    output logic                  s_read,
    output logic                  s_write,
    output logic [DATA_W-1:0]     s_writedata,
    output logic [DATA_W/8-1:0]   s_byteenable,
    input  logic                  s_waitrequest,
    input  logic [DATA_W-1:0]     s_readdata,
    output logic [CNT_W-1:0]      rd_count,
    output logic [CNT_W-1:0]      wr_count,
    output logic                  protocol_err
);

    localparam int D_MAX = (WAIT_CYCLES > MAX_WAIT) ? WAIT_CYCLES : MAX_WAIT;
    localparam int SC_W  = $clog2(D_MAX + 1) + 1;

    bridge_state_t         r_state;
    bridge_state_t         w_next;
    logic [SC_W-1:0]       r_stall;
    logic [SC_W-1:0]       w_d;
    logic [ADDR_W-1:0]     r_addr;
    logic [DATA_W-1:0]     r_wd;
    logic [DATA_W/8-1:0]   r_be;
    op_t                   r_op;
    logic                  r_dropped;
    logic                  w_req;
    logic                  w_chg;
    logic                  w_err;

    assign w_req = read | write;

`ifdef AVB_STALL_LFSR_EN
    logic [15:0] w_lfsr;
    logic        w_accept;

    assign w_accept = (r_state == IDLE) && w_req;

    stall_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .i_clk   (clk),
        .i_reset (reset),
        .i_adv   (w_accept),
        .o_lfsr  (w_lfsr)
    );

    assign w_d = SC_W'(w_lfsr % 16'(MAX_WAIT + 1));
`else
    logic w_unused_seed;

    assign w_unused_seed = ^LFSR_SEED;
    assign w_d           = SC_W'(WAIT_CYCLES);
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_req) w_next = (w_d == '0) ? ISSUE : STALL;
            STALL:   if (!w_req) w_next = IDLE;
                     else if (r_stall == SC_W'(1)) w_next = ISSUE;
            // An abandoned request still lets the RAM finish, but skips DONE.
            ISSUE:   if (!s_waitrequest) w_next = (r_dropped || !w_req) ? IDLE : DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign w_chg = (address != r_addr) || (byteenable != r_be) || (writedata != r_wd);
    assign w_err = (read && write) ||
                   (((r_state == STALL) || (r_state == ISSUE)) && (!w_req || w_chg));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_stall      <= '0;
            r_addr       <= '0;
            r_wd         <= '0;
            r_be         <= '0;
            r_op         <= OP_RD;
            r_dropped    <= 1'b0;
            readdata     <= '0;
            rd_count     <= '0;
            wr_count     <= '0;
            protocol_err <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: if (w_req) begin
                    r_addr    <= address;
                    r_wd      <= writedata;
                    r_be      <= byteenable;
                    r_op      <= write ? OP_WR : OP_RD;
                    r_stall   <= w_d;
                    r_dropped <= 1'b0;
                end
                STALL: r_stall <= r_stall - 1'b1;
                ISSUE: begin
                    if (!w_req) r_dropped <= 1'b1;
                    if (!s_waitrequest && (r_op == OP_RD)) readdata <= s_readdata;
                end
                DONE: begin
                    if (r_op == OP_RD) begin
                        if (rd_count != '1) rd_count <= rd_count + 1'b1;
                    end else begin
                        if (wr_count != '1) wr_count <= wr_count + 1'b1;
                    end
                end
                default: ;
            endcase
            if (w_err) protocol_err <= 1'b1;
        end
    end

    assign waitrequest  = w_req && (r_state != DONE);
    assign s_read       = (r_state == ISSUE) && (r_op == OP_RD);
    assign s_write      = (r_state == ISSUE) && (r_op == OP_WR);
    assign s_address    = r_addr;
    assign s_writedata  = r_wd;
    assign s_byteenable = r_be;

endmodule

// File: tb/tb_avalon_stall_bridge.sv
// Directed self-checking bench for avalon_stall_bridge with a RAM slave and a transaction-level model.
module tb_avalon_stall_bridge;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = 4;
    localparam int CW = 3;
    localparam int WC = 2;
    localparam int MW = 7;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] address;
    logic          read;
    logic          write;
    logic [DW-1:0] writedata;
    logic [BW-1:0] byteenable;
    logic          waitrequest;
    logic [DW-1:0] readdata;
    logic [AW-1:0] s_address;
    logic          s_read;
    logic          s_write;
    logic [DW-1:0] s_writedata;
    logic [BW-1:0] s_byteenable;
    logic          s_waitrequest;
    logic [DW-1:0] s_readdata;
    logic [CW-1:0] rd_count;
    logic [CW-1:0] wr_count;
    logic          protocol_err;

    always #5 clk = ~clk;

    avalon_stall_bridge #(
        .ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(WC), .MAX_WAIT(MW),
        .LFSR_SEED(16'hACE1), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
        .writedata(writedata), .byteenable(byteenable), .waitrequest(waitrequest),
        .readdata(readdata), .s_address(s_address), .s_read(s_read), .s_write(s_write),
        .s_writedata(s_writedata), .s_byteenable(s_byteenable),
        .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
        .rd_count(rd_count), .wr_count(wr_count), .protocol_err(protocol_err)
    );

    function automatic logic [31:0] init_val(input int i);
        if (i == 1) return 32'h0140_0008;
        if (i == 4) return 32'h1122_3344;
        return 32'hA500_0000 | i;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        return r;
    endfunction

    // RAM slave: holds s_waitrequest for ram_cfg cycles of each access
    logic [31:0] ram [0:15];
    logic        ram_load;
    int          ram_cfg = 0;
    int          ram_cnt = 0;

    assign s_waitrequest = (s_read || s_write) && (ram_cnt < ram_cfg);
    assign s_readdata    = ram[s_address[5:2]];

    always @(posedge clk) begin
        if (ram_load) begin
            for (int i = 0; i < 16; i++) ram[i] = init_val(i);
        end
        if (s_read || s_write) begin
            if (ram_cnt < ram_cfg) ram_cnt <= ram_cnt + 1;
            else begin
                ram_cnt <= 0;
                if (s_write) ram[s_address[5:2]] = merge(ram[s_address[5:2]], s_writedata, s_byteenable);
            end
        end else begin
            ram_cnt <= 0;
        end
    end

    // Model state and per-window expectations
    logic [31:0] exp_mem [0:15];
    logic [15:0] lfsr_m;
    logic        chk_en;
    logic        e_wait, e_srd, e_swr, e_rdchk, e_err;
    logic [31:0] e_addr, e_wd, e_rdata;
    logic [3:0]  e_be;
    int          e_rdc, e_wrc;
    int          checks = 0;
    int          failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic int satc(input int v);
        return (v > CNT_MAX) ? CNT_MAX : v;
    endfunction

    function automatic int next_d();
        int d;
`ifdef AVB_STALL_LFSR_EN
        d = int'(lfsr_m) % (MW + 1);
        lfsr_m = (lfsr_m >> 1) ^ (lfsr_m[0] ? 16'hB400 : 16'h0000);
`else
        d = WC;
`endif
        return d;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("waitrequest", waitrequest, e_wait);
            check("s_read", s_read, e_srd);
            check("s_write", s_write, e_swr);
            if (e_srd || e_swr) begin
                check("s_address", s_address, e_addr);
                check("s_byteenable", s_byteenable, e_be);
                if (e_swr) check("s_writedata", s_writedata, e_wd);
            end
            if (e_rdchk) check("readdata", readdata, e_rdata);
            check("rd_count", rd_count, satc(e_rdc));
            check("wr_count", wr_count, satc(e_wrc));
            check("protocol_err", protocol_err, e_err);
        end
    end

    // One CPU transfer; drop_j/chg_j (>=1) pick the window where the CPU drops or alters its request.
    task automatic xfer(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] be, input int w,
                        input int drop_j, input int chg_j,
                        output int wcount, output int d, output logic [31:0] rd_out);
        int   last, err_at, done_j;
        logic dstall, req, in_iss;
        d      = next_d();
        done_j = 2 + d + w;
        dstall = (drop_j >= 1) && (drop_j <= d);
        last   = dstall ? drop_j : done_j;
        err_at = 1 << 30;
        if (rd && wr) err_at = 1;
        if (drop_j >= 1 && drop_j + 1 < err_at) err_at = drop_j + 1;
        if (chg_j >= 1 && chg_j + 1 < err_at) err_at = chg_j + 1;
        ram_cfg = w;
        wcount  = 0;
        rd_out  = '0;
        e_addr  = addr;
        e_wd    = wd;
        e_be    = be;
        e_rdata = exp_mem[addr[5:2]];
        for (int j = 0; j <= last + 1; j++) begin
            @(posedge clk); #1;
            req        = (drop_j < 0 || j < drop_j) && (j <= last);
            in_iss     = !dstall && (j >= 1 + d) && (j <= 1 + d + w);
            read       = rd && req;
            write      = wr && req;
            address    = (chg_j >= 1 && j >= chg_j) ? (addr ^ 32'h4) : addr;
            writedata  = wd;
            byteenable = be;
            e_wait     = req && (j != done_j);
            e_srd      = in_iss && !wr;
            e_swr      = in_iss && wr;
            e_rdchk    = (j == done_j) && !wr && (drop_j < 0);
            if (j >= err_at) e_err = 1'b1;
            if (j == last + 1) begin
                if (drop_j < 0) begin
                    if (wr) e_wrc++;
                    else e_rdc++;
                end
                if (wr && !dstall) exp_mem[addr[5:2]] = merge(exp_mem[addr[5:2]], wd, be);
            end
            @(negedge clk);
            if (waitrequest) wcount++;
            if (j == done_j) rd_out = readdata;
        end
    endtask

    task automatic do_reset();
        chk_en = 1'b0;
        reset  = 1'b1;
        read   = 1'b0;
        write  = 1'b0;
        e_wait = 1'b0; e_srd = 1'b0; e_swr = 1'b0; e_rdchk = 1'b0; e_err = 1'b0;
        e_rdc  = 0;    e_wrc = 0;
        lfsr_m = 16'hACE1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk_en = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          wc, d;
        logic [31:0] rdo;
        chk_en = 1'b0; ram_load = 1'b1; reset = 1'b1;
        read = 1'b0; write = 1'b0; address = '0; writedata = '0; byteenable = '0;
        for (int i = 0; i < 16; i++) exp_mem[i] = init_val(i);
        @(posedge clk); #1 ram_load = 1'b0;
        check("rst_waitrequest", waitrequest, 1'b0);
        check("rst_readdata", readdata, 32'h0);
        check("rst_sread", s_read, 1'b0);
        check("rst_counts", {rd_count, wr_count}, 0);
        check("rst_err", protocol_err, 1'b0);
        do_reset();
`ifdef AVB_STALL_LFSR_EN
        for (int i = 0; i < 100; i++) begin
            xfer(1'b1, 1'b0, (i * 4) & 32'h3C, 32'h0, 4'hF, 0, -1, -1, wc, d, rdo);
            check("lfsr_stall_len", wc - 2, d);
            check("lfsr_stall_range", (wc >= 2) && (wc <= 2 + MW), 1'b1);
        end
`else
        // 1: plain read
        xfer(1'b1, 1'b0, 32'h04, 32'h0, 4'hF, 0, -1, -1, wc, d, rdo);
        check("t1_wait_cycles", wc, 4);
        check("t1_readdata", rdo, 32'h0140_0008);
        check("t1_rd_count", rd_count, 1);
        // 2: partial write then read back
        xfer(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'b0011, 0, -1, -1, wc, d, rdo);
        check("t2_ram_word", ram[4], 32'h1122_BEEF);
        check("t2_wr_count", wr_count, 1);
        xfer(1'b1, 1'b0, 32'h10, 32'h0, 4'hF, 0, -1, -1, wc, d, rdo);
        check("t2_readback", rdo, 32'h1122_BEEF);
        // 3: RAM stalls 3 cycles
        xfer(1'b1, 1'b0, 32'h04, 32'h0, 4'hF, 3, -1, -1, wc, d, rdo);
        check("t3_wait_cycles", wc, 7);
        check("t3_err_clear", protocol_err, 1'b0);
        // 5: read and write together is a write
        xfer(1'b1, 1'b1, 32'h08, 32'hCAFE_F00D, 4'hF, 0, -1, -1, wc, d, rdo);
        check("t5_ram_word", ram[2], 32'hCAFE_F00D);
        check("t5_wr_count", wr_count, 2);
        check("t5_err", protocol_err, 1'b1);
        // 4: request dropped after one stall cycle
        do_reset();
        xfer(1'b1, 1'b0, 32'h04, 32'h0, 4'hF, 0, -1, -1, wc, d, rdo);
        xfer(1'b1, 1'b0, 32'h0C, 32'h0, 4'hF, 0, 2, -1, wc, d, rdo);
        check("t4_rd_count", rd_count, 1);
        check("t4_err", protocol_err, 1'b1);
        // 6: reset while the RAM access is in flight
        chk_en = 1'b0;
        ram_cfg = 3;
        @(posedge clk); #1;
        read = 1'b1; address = 32'h04; byteenable = 4'hF; writedata = '0;
        repeat (3) @(posedge clk);
        #1 check("t6_sread_pre", s_read, 1'b1);
        #2 reset = 1'b1; read = 1'b0;
        #1;
        check("t6_sread", s_read, 1'b0);
        check("t6_swrite", s_write, 1'b0);
        check("t6_waitrequest", waitrequest, 1'b0);
        check("t6_readdata", readdata, 32'h0);
        check("t6_counts", {rd_count, wr_count}, 0);
        check("t6_err", protocol_err, 1'b0);
        do_reset();
        xfer(1'b1, 1'b0, 32'h04, 32'h0, 4'hF, 0, -1, -1, wc, d, rdo);
        check("t6_after_readdata", rdo, 32'h0140_0008);
        check("t6_after_rd_count", rd_count, 1);
        // Request dropped while the RAM is still stalling
        xfer(1'b1, 1'b0, 32'h10, 32'h0, 4'hF, 2, 4, -1, wc, d, rdo);
        check("drop_issue_rd_count", rd_count, 1);
        check("drop_issue_err", protocol_err, 1'b1);
        // Address changed during stall
        do_reset();
        xfer(1'b1, 1'b0, 32'h04, 32'h0, 4'hF, 0, -1, 1, wc, d, rdo);
        check("chg_readdata", rdo, 32'h0140_0008);
        check("chg_err", protocol_err, 1'b1);
        // Counter saturation
        do_reset();
        for (int i = 0; i < 9; i++) xfer(1'b1, 1'b0, 32'h08, 32'h0, 4'hF, 0, -1, -1, wc, d, rdo);
        check("sat_rd_count", rd_count, 3'h7);
        check("sat_readdata", rdo, 32'hCAFE_F00D);
`endif
        @(posedge clk); #1 chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
